// File: rtl/mem_wb_stage_if.sv
// Pipeline-side and data-memory-side signals of the MEM/WB stage.
// The slave modport is the stage; the master modport is whatever feeds and serves it.
interface mem_wb_stage_if #(
    parameter int XLEN = 64
);
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] store_data;
    logic            mem_we;
    logic            mem_to_reg;
    logic            rd_we;
    logic [4:0]      rd_addr;

    logic            dmem_req;
    logic            dmem_we;
    logic [XLEN-1:0] dmem_addr;
    logic [XLEN-1:0] dmem_wdata;
    logic            dmem_gnt;
    logic            dmem_rvalid;
    logic [XLEN-1:0] dmem_rdata;

    logic            wb_valid;
    logic            wb_rd_we;
    logic [4:0]      wb_rd_addr;
    logic [XLEN-1:0] wb_data;

    modport master (
        output in_valid, alu_result, store_data, mem_we, mem_to_reg, rd_we, rd_addr,
        output dmem_gnt, dmem_rvalid, dmem_rdata,
        input  in_ready, dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  wb_valid, wb_rd_we, wb_rd_addr, wb_data
    );

    modport slave (
        input  in_valid, alu_result, store_data, mem_we, mem_to_reg, rd_we, rd_addr,
        input  dmem_gnt, dmem_rvalid, dmem_rdata,
        output in_ready, dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output wb_valid, wb_rd_we, wb_rd_addr, wb_data
    );
endinterface

// File: rtl/mem_wb_stage.sv
// Memory/writeback stage: one result in flight, optional data-memory access,
// then a single-cycle register-file write.
module mem_wb_stage #(
    parameter int XLEN = 64
) (
    input  logic          clk,
    input  logic          rst,
    mem_wb_stage_if.slave bus
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT_R, WB} state_t;

    state_t          state_reg;
    state_t          state_next;
    logic [XLEN-1:0] addr_reg;
    logic [XLEN-1:0] wdata_reg;
    logic            store_reg;
    logic            rd_we_reg;
    logic [4:0]      rd_addr_reg;
    logic [XLEN-1:0] wb_data_reg;
    logic [4:0]      wb_rd_addr_reg;
    logic            accept;
    logic            is_mem_op;

    assign accept    = bus.in_valid && (state_reg == IDLE);
    assign is_mem_op = bus.mem_we || bus.mem_to_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = is_mem_op ? REQ : WB;
            REQ:     if (bus.dmem_gnt) state_next = store_reg ? WB : WAIT_R;
            WAIT_R:  if (bus.dmem_rvalid) state_next = WB;
            WB:      state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // rd_we_reg already folds in the x0 and store exclusions, so it can drive
    // wb_rd_we directly during WB.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_reg       <= '0;
            wdata_reg      <= '0;
            store_reg      <= 1'b0;
            rd_we_reg      <= 1'b0;
            rd_addr_reg    <= '0;
            wb_data_reg    <= '0;
            wb_rd_addr_reg <= '0;
        end else begin
            if (accept) begin
                addr_reg    <= bus.alu_result;
                wdata_reg   <= bus.store_data;
                store_reg   <= bus.mem_we;
                rd_addr_reg <= bus.rd_addr;
                rd_we_reg   <= bus.rd_we && (bus.rd_addr != 5'd0) && !bus.mem_we;
            end
            // Writeback fields change only on entry to WB so they hold otherwise.
            if (accept && !is_mem_op) begin
                wb_data_reg    <= bus.alu_result;
                wb_rd_addr_reg <= bus.rd_addr;
            end
            if ((state_reg == REQ) && bus.dmem_gnt && store_reg) begin
                wb_data_reg    <= addr_reg;
                wb_rd_addr_reg <= rd_addr_reg;
            end
            if ((state_reg == WAIT_R) && bus.dmem_rvalid) begin
                wb_data_reg    <= bus.dmem_rdata;
                wb_rd_addr_reg <= rd_addr_reg;
            end
        end
    end

    always_comb begin
        bus.in_ready = (state_reg == IDLE);
        bus.dmem_req = (state_reg == REQ);
        bus.dmem_we  = (state_reg == REQ) && store_reg;
        bus.wb_valid = (state_reg == WB);
        bus.wb_rd_we = (state_reg == WB) && rd_we_reg;
    end

    assign bus.dmem_addr  = addr_reg;
    assign bus.dmem_wdata = wdata_reg;
    assign bus.wb_data    = wb_data_reg;
    assign bus.wb_rd_addr = wb_rd_addr_reg;
endmodule

// File: doc/mem_wb_stage.md
MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 The block SHALL take parameter XLEN, default 64, as the datapath width; only 64 is supported.
REQ-002 The block SHALL have port clk  input  1  rising-edge clock.
REQ-003 The block SHALL have port rst  input  1  asynchronous active-high reset.
REQ-004 The block SHALL have port in_valid  input  1  execute result present.
REQ-005 The block SHALL have port in_ready  output  1  stage can accept a result.
REQ-006 The block SHALL have port alu_result  input  64  ALU value or effective address.
REQ-007 The block SHALL have port store_data  input  64  store write data.
REQ-008 The block SHALL have port mem_we  input  1  store op.
REQ-009 The block SHALL have port mem_to_reg  input  1  load op.
REQ-010 The block SHALL have port rd_we  input  1  destination write enable.
REQ-011 The block SHALL have port rd_addr  input  5  destination register index.
REQ-012 The block SHALL have port dmem_req  output  1  memory request.
REQ-013 The block SHALL have port dmem_we  output  1  request is a write.
REQ-014 The block SHALL have ports dmem_addr and dmem_wdata  output  64 each  request address and data.
REQ-015 The block SHALL have port dmem_gnt  input  1  request accepted this cycle.
REQ-016 The block SHALL have ports dmem_rvalid  input  1 and dmem_rdata  input  64  load response.
REQ-017 The block SHALL have ports wb_valid  output  1, wb_rd_we  output  1, wb_rd_addr  output  5, wb_data  output  64  register-file write port.

Function
REQ-018 The FSM SHALL have states IDLE, REQ, WAIT_R, WB; in_ready SHALL be 1 only in IDLE.
REQ-019 On in_valid&&in_ready, the block SHALL register all inputs and go to REQ if mem_we or mem_to_reg, else to WB.
REQ-020 If mem_we and mem_to_reg are both 1, the op SHALL be treated as a store.
REQ-021 In REQ: dmem_req=1; dmem_addr, dmem_we and dmem_wdata from registered values, held stable until dmem_gnt.
REQ-022 On REQ with dmem_gnt=1: store -> WB; load -> WAIT_R.
REQ-023 dmem_rvalid SHALL be honoured only in WAIT_R and ignored in every other state.
REQ-024 In WAIT_R with dmem_rvalid=1, the block SHALL capture dmem_rdata as the writeback value and go to WB.
REQ-025 In WB, wb_valid SHALL be 1 for exactly one cycle, then the FSM SHALL return to IDLE.
REQ-026 wb_data SHALL be the loaded data for a load, otherwise the registered alu_result.
REQ-027 wb_rd_we SHALL be registered rd_we AND (rd_addr != 0); it SHALL be 0 for stores.
REQ-028 Outside WB, wb_valid and wb_rd_we SHALL be 0 and wb_data/wb_rd_addr SHALL hold their last value.
REQ-029 Outside REQ, dmem_req and dmem_we SHALL be 0.
REQ-030 Latency, accept at cycle T:
- ALU op: wb_valid at T+1.
- Store with immediate grant: dmem_req at T+1, wb_valid at T+2.
- Load with immediate grant and rvalid one cycle later: wb_valid at T+3.
- Each grant or response wait cycle adds one cycle.
REQ-031 There SHALL be no timeout; the block SHALL wait indefinitely in REQ or WAIT_R.

Reset
REQ-032 While rst=1, asynchronously: FSM=IDLE; in_ready=1; dmem_req, dmem_we, wb_valid, wb_rd_we=0; dmem_addr, dmem_wdata, wb_data=0; wb_rd_addr=0.
REQ-033 Reset asserted in REQ or WAIT_R SHALL abandon the transaction with no writeback; a late dmem_rvalid after reset SHALL be ignored.

Verification
REQ-034 ALU op, alu_result=0x1234, rd_addr=5, rd_we=1 -> next cycle wb_valid=1, wb_rd_addr=5, wb_data=0x1234, wb_rd_we=1.
REQ-035 Load, addr=0x100, gnt after 2 wait cycles, rvalid=1 with rdata=0xDEADBEEF two cycles after gnt -> dmem_addr held at 0x100 while waiting; single wb_valid with wb_data=0xDEADBEEF.
REQ-036 Store, addr=0x200, data=0xAA, immediate gnt -> dmem_we=1, dmem_wdata=0xAA for one cycle; wb_valid=1 with wb_rd_we=0.
REQ-037 ALU op with rd_addr=0, rd_we=1 -> wb_valid=1, wb_rd_we=0; also mem_we=mem_to_reg=1 -> handled as a store.
REQ-038 Reset in WAIT_R, then rvalid pulse -> no wb_valid, in_ready=1 immediately; a following ALU op completes normally.
REQ-039 Back-to-back in_valid held high -> in_ready=0 from accept until return to IDLE; no input lost or duplicated.
